divider_requester: RTL
======================

// Module: divider_requester
// PURPOSE
//  Initiator end of the divider Start/Done/Ack handshake. Sweeps every (X,Y)
//  operand pair with Y!=0 and issues each pair to a divider. Captures the
//  Quotient/Remainder, checks that Q*Y+R==X and R<Y, then acknowledges.
//  Sits beside the divider as a self-test/sequencer; shares its Clk and Reset.
// PARAMETERS
//  WIDTH    4    operand/result width; sweep covers 2^W*(2^W-1) pairs
//  TIMEOUT  64   max cycles waiting for Done before declaring a hang
// PORTS
//  Clk        in   1      single clock, all state updates on posedge
//  Reset      in   1      synchronous, active-high
//  Go         in   1      level; rising use in IDLE starts a sweep
//  Done       in   1      divider result valid
//  Quotient   in   W      divider quotient
//  Remainder  in   W      divider remainder
//  Xout       out  W      dividend to divider (registered)
//  Yout       out  W      divisor to divider (registered)
//  Start      out  1      one-cycle request pulse
//  Ack        out  1      result acknowledge
//  Busy       out  1      sweep in progress
//  Finished   out  1      sweep complete (or aborted by timeout)
//  PassCount  out  2W     pairs that checked correct
//  ErrCount   out  2W     pairs that failed the check
//  ErrX/ErrY  out  W,W    first failing pair; valid when ErrCount!=0
//  TimeoutErr out  1      sticky; Done not seen within TIMEOUT cycles
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high (Clk, Reset).
//  Reset values: state=IDLE; Xout=0; Yout=1; Start=Ack=Busy=Finished=0;
//   counts=0; ErrX=ErrY=0; TimeoutErr=0. Reset mid-sweep aborts at once;
//   no Ack is sent. The divider shares Reset, so both return to their idle state.
//  States (one-hot): IDLE, ISSUE, WAIT, CHECK, ACK, FINISH.
//  IDLE:   Go=1 -> clear counts/err regs, Xout=0, Yout=1, Busy=1 -> ISSUE.
//  ISSUE:  Xout/Yout already stable >=1 cycle; Start=1 for exactly this cycle
//          -> WAIT. Xout/Yout stay frozen until ACK exits.
//  WAIT:   Done=1 -> CHECK. Watchdog counts cycles in WAIT.
//          At TIMEOUT: TimeoutErr=1, Finished=1, Busy=0 -> FINISH.
//  CHECK:  register Q,R. Pass iff Q*Yout+R == Xout, computed at 2W bits
//          without truncation, and R<Yout. Pass: PassCount++. Fail:
//          ErrCount++; ErrX/ErrY load only when ErrCount was 0 -> ACK.
//  ACK:    Ack=1 held while Done=1. Done=0 seen: Ack=0 and advance the pair.
//          Yout++; if Yout was 2^W-1 -> Yout=1, Xout++.
//          Last pair (X=Y=2^W-1): -> FINISH; otherwise -> ISSUE.
//  FINISH: Finished=1, Busy=0, counts held. Go=0 -> IDLE with counts still
//          held; a new Go clears them.
//  Latency: Start to the next Start is divider latency + 4 cycles minimum.
//  Y=0 is never issued: the divider does not terminate on it.
//  Counters saturate at 2^(2W)-1. At default W, 240 pairs never saturate.
//  Done already high when entering WAIT is legal and is accepted next cycle.
//  Go dropping mid-sweep is ignored; only Reset aborts.
// STRUCTURE
//  Package divider_pkg: WIDTH default, one-hot state localparams,
//   divider_checker function or port widths.
//  Sub-module divider_checker (combinational): inputs X,Y,Q,R; output pass.
//   It is reusable by the divider's own bench.
//  The rest is one clocked always block covering control and datapath.
// TESTING (bench pairs DUT with a behavioural divider; fault-injection option)
//  1 Correct divider, W=4, Go=1 -> 240 Start pulses;
//    PassCount=240, ErrCount=0, Finished=1.
//  2 First pair -> Xout=0, Yout=1 at Start; X=7,Y=3 returns Q=2,R=1 and passes.
//  3 Force R=Y on X=9,Y=4 (Q=1,R=4 -> Q*Y+R is 8, wrong) ->
//    ErrCount=1, ErrX=9, ErrY=4; sweep continues.
//  4 Divider never raises Done -> TimeoutErr=1 and Finished=1 after 64 WAIT
//    cycles; Start issued once.
//  5 Assert Reset during ACK with Done high -> next cycle Ack=0,
//    Busy=0, counts=0, state IDLE.
//  6 Done held high 5 cycles after Ack -> Ack stays high until Done drops;
//    no second count, no early Start.

Source files
------------

// File: rtl/divider_pkg.sv
// divider_pkg: shared defaults and one-hot state encoding for the divider requester
package divider_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int TIMEOUT_DEF = 64;
  typedef logic [5:0] state_t;
  localparam state_t S_IDLE   = 6'b000001;
  localparam state_t S_ISSUE  = 6'b000010;
  localparam state_t S_WAIT   = 6'b000100;
  localparam state_t S_CHECK  = 6'b001000;
  localparam state_t S_ACK    = 6'b010000;
  localparam state_t S_FINISH = 6'b100000;
endpackage

// File: rtl/divider_checker.sv
// divider_checker: combinational check that Q*Y+R==X and R<Y
module divider_checker
  import divider_pkg::*;
#(
  parameter int W = WIDTH_DEF
) (
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  input  logic [W-1:0] Q,
  input  logic [W-1:0] R,
  output logic         pass
);
  logic [2*W-1:0] recon;
  always_comb begin
    recon = {{W{1'b0}}, Q} * {{W{1'b0}}, Y} + {{W{1'b0}}, R};
    pass = (recon == {{W{1'b0}}, X}) && (R < Y);
  end
endmodule

// File: rtl/divider_requester.sv
// divider_requester: sweeps all (X,Y!=0) pairs through a divider and checks each result
module divider_requester
  import divider_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Go,
  input  logic               Done,
  input  logic [WIDTH-1:0]   Quotient,
  input  logic [WIDTH-1:0]   Remainder,
  output logic [WIDTH-1:0]   Xout,
  output logic [WIDTH-1:0]   Yout,
  output logic               Start,
  output logic               Ack,
  output logic               Busy,
  output logic               Finished,
  output logic [2*WIDTH-1:0] PassCount,
  output logic [2*WIDTH-1:0] ErrCount,
  output logic [WIDTH-1:0]   ErrX,
  output logic [WIDTH-1:0]   ErrY,
  output logic               TimeoutErr
);
  localparam int W = WIDTH;
  localparam int CW = 2 * WIDTH;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, state_nxt;
  logic [TW-1:0] wdog;
  logic [W-1:0] q_r, r_r;
  logic pass, ymax, last, timeout;
  assign ymax = Yout == {W{1'b1}};
  assign last = ymax && (Xout == {W{1'b1}});
  assign timeout = wdog == TW'(TIMEOUT - 1);
  divider_checker #(.W(W)) u_chk (.X(Xout), .Y(Yout), .Q(q_r), .R(r_r), .pass(pass));
  always_ff @(posedge Clk) begin
    if (Reset) state <= S_IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (Go) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT:   state_nxt = Done ? S_CHECK : timeout ? S_FINISH : S_WAIT;
      S_CHECK:  state_nxt = S_ACK;
      S_ACK:    if (!Done) state_nxt = last ? S_FINISH : S_ISSUE;
      S_FINISH: if (!Go) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end
  always_comb begin
    Start = state == S_ISSUE;
    Ack = state == S_ACK;
    Finished = state == S_FINISH;
    Busy = !(state == S_IDLE || state == S_FINISH);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Xout <= '0;
      Yout <= W'(1);
      PassCount <= '0;
      ErrCount <= '0;
      ErrX <= '0;
      ErrY <= '0;
      TimeoutErr <= 1'b0;
      wdog <= '0;
      q_r <= '0;
      r_r <= '0;
    end else begin
      wdog <= (state == S_WAIT) ? wdog + TW'(1) : '0;
      if (state == S_IDLE && Go) begin
        Xout <= '0;
        Yout <= W'(1);
        PassCount <= '0;
        ErrCount <= '0;
        ErrX <= '0;
        ErrY <= '0;
        TimeoutErr <= 1'b0;
      end
      if (state == S_WAIT && Done) begin
        q_r <= Quotient;
        r_r <= Remainder;
      end
      if (state == S_WAIT && !Done && timeout) TimeoutErr <= 1'b1;
      if (state == S_CHECK && pass && PassCount != '1) PassCount <= PassCount + CW'(1);
      if (state == S_CHECK && !pass) begin
        if (ErrCount != '1) ErrCount <= ErrCount + CW'(1);
        if (ErrCount == '0) begin
          ErrX <= Xout;
          ErrY <= Yout;
        end
      end
      // Y wraps to 1, never 0: the divider would not terminate on a zero divisor
      if (state == S_ACK && !Done) begin
        Yout <= ymax ? W'(1) : Yout + W'(1);
        if (ymax) Xout <= Xout + W'(1);
      end
    end
  end
endmodule
